bsg_fifo_rolly_replay_tx: RTL and testbench



---
 rtl/bsg_fifo_rolly_replay_tx.sv | 112 +++++++++++
 tb/tb_bsg_fifo_rolly_replay_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_rolly_replay_tx.sv
// Go-back-N transmit side of a rollback FIFO: sends entries speculatively, retires
// them on ack, and rewinds the FIFO read pointer on nack or ack timeout.
module bsg_fifo_rolly_replay_tx #(
    parameter int width_p      = 8,
    parameter int els_p        = 4,
    parameter int timeout_p    = 64,
    parameter int cnt_width_lp = (els_p + 1 > 1) ? $clog2(els_p + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      fifo_data_i,
    input  logic                    fifo_v_i,
    output logic                    fifo_yumi_o,
    output logic                    fifo_deq_v_o,
    output logic                    fifo_rollback_v_o,
    output logic [width_p-1:0]      link_data_o,
    output logic                    link_v_o,
    input  logic                    link_ready_and_i,
    input  logic                    ack_v_i,
    input  logic [cnt_width_lp-1:0] ack_cnt_i,
    input  logic                    nack_v_i
);

    localparam int timer_width_lp = (timeout_p > 2) ? $clog2(timeout_p) : 1;
    localparam logic [cnt_width_lp-1:0]   els_lp         = cnt_width_lp'(els_p);
    localparam logic [timer_width_lp-1:0] timer_limit_lp = timer_width_lp'(timeout_p - 1);

    typedef enum logic [1:0] {
        eSend,
        eDrain,
        eRollback
    } state_e;

    state_e                    state_q, state_d;
    logic [cnt_width_lp-1:0]   inflight_q, inflight_d;
    logic [cnt_width_lp-1:0]   retire_q, retire_d;
    logic [timer_width_lp-1:0] timer_q, timer_d;

    logic                    link_v;
    logic                    yumi;
    logic                    deq;
    logic                    ack_fire;
    logic                    ack_clear;
    logic                    timeout_hit;
    logic [cnt_width_lp-1:0] ack_amt;

    assign link_data_o       = fifo_data_i;
    assign link_v_o          = link_v;
    assign fifo_yumi_o       = yumi;
    assign fifo_deq_v_o      = deq;
    assign fifo_rollback_v_o = (state_q == eRollback) & ~reset_i;

    always_comb begin
        link_v      = fifo_v_i & (state_q == eSend) & (inflight_q < els_lp) & ~reset_i;
        yumi        = link_v & link_ready_and_i;
        deq         = (retire_q != '0) & ~reset_i;
        ack_fire    = ack_v_i & (state_q == eSend);
        ack_amt     = ack_fire ? ack_cnt_i : '0;
        ack_clear   = ack_fire & (ack_cnt_i != '0);
        timeout_hit = (timer_q == timer_limit_lp) & ~ack_clear;
    end

    // Acks are applied before any nack/timeout decision taken in the same cycle.
    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q + cnt_width_lp'(yumi) - ack_amt;
        retire_d   = retire_q + ack_amt - cnt_width_lp'(deq);
        if ((state_q != eSend) || (inflight_q == '0) || ack_clear) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        unique case (state_q)
            eSend: begin
                if (nack_v_i || timeout_hit) begin
                    state_d = eDrain;
                end
            end
            eDrain: begin
                if (retire_q == '0) begin
                    state_d = eRollback;
                end
            end
            eRollback: begin
                state_d    = eSend;
                inflight_d = '0;
                timer_d    = '0;
            end
            default: state_d = eSend;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= eSend;
            inflight_q <= '0;
            retire_q   <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            retire_q   <= retire_d;
            timer_q    <= timer_d;
        end
    end

    // The far end may never acknowledge more entries than are outstanding.
    ack_le_inflight: assert property (@(posedge clk_i) disable iff (reset_i)
        (ack_v_i && state_q == eSend) |-> (ack_cnt_i <= inflight_q));

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_tx.sv
// Directed bench for bsg_fifo_rolly_replay_tx with a small rollback-FIFO model
// feeding it; expected values are hand-derived cycle counts and payloads.
module tb_bsg_fifo_rolly_replay_tx;

    localparam int width_p   = 8;
    localparam int els_p     = 4;
    localparam int timeout_p = 8;
    localparam int cnt_w     = 3;

    logic               clk_i = 1'b0;
    logic               reset_i = 1'b1;
    logic [width_p-1:0] fifo_data_i;
    logic               fifo_v_i;
    logic               fifo_yumi_o;
    logic               fifo_deq_v_o;
    logic               fifo_rollback_v_o;
    logic [width_p-1:0] link_data_o;
    logic               link_v_o;
    logic               link_ready_and_i = 1'b1;
    logic               ack_v_i = 1'b0;
    logic [cnt_w-1:0]   ack_cnt_i = '0;
    logic               nack_v_i = 1'b0;

    bsg_fifo_rolly_replay_tx #(
        .width_p  (width_p),
        .els_p    (els_p),
        .timeout_p(timeout_p)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fifo_data_i      (fifo_data_i),
        .fifo_v_i         (fifo_v_i),
        .fifo_yumi_o      (fifo_yumi_o),
        .fifo_deq_v_o     (fifo_deq_v_o),
        .fifo_rollback_v_o(fifo_rollback_v_o),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i),
        .ack_v_i          (ack_v_i),
        .ack_cnt_i        (ack_cnt_i),
        .nack_v_i         (nack_v_i)
    );

    always #5 clk_i = ~clk_i;

    logic [width_p-1:0] mem [0:31];
    int                 wr_ptr = 0;
    int                 rd_ptr = 0;
    int                 cp_ptr = 0;
    int                 yumi_cnt = 0;
    int                 deq_cnt = 0;
    logic [width_p-1:0] sent_q [$];

    assign fifo_v_i    = (rd_ptr != wr_ptr);
    assign fifo_data_i = mem[rd_ptr % 32];

    // Rollback FIFO model plus a log of everything the link accepted.
    always @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr <= wr_ptr;
            cp_ptr <= wr_ptr;
        end else begin
            if (fifo_rollback_v_o) rd_ptr <= cp_ptr;
            else if (fifo_yumi_o)  rd_ptr <= rd_ptr + 1;
            if (fifo_deq_v_o)      cp_ptr <= cp_ptr + 1;
            if (fifo_yumi_o) begin
                yumi_cnt <= yumi_cnt + 1;
                sent_q.push_back(link_data_o);
            end
            if (fifo_deq_v_o) deq_cnt <= deq_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic ack_v, input logic [cnt_w-1:0] ack_cnt, input logic nack_v);
        ack_v_i   = ack_v;
        ack_cnt_i = ack_cnt;
        nack_v_i  = nack_v;
    endtask

    task automatic pushEntry(input logic [width_p-1:0] d);
        mem[wr_ptr % 32] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [3:0] allOut();
        return {fifo_yumi_o, fifo_deq_v_o, fifo_rollback_v_o, link_v_o};
    endfunction

    initial begin
        int base_y, base_s, base_d, rb_idx;
        logic [width_p-1:0] d_vals [0:5];
        logic deq_seq [1:7];
        logic rb_seq  [1:7];

        d_vals[0] = 8'hD0; d_vals[1] = 8'hD1; d_vals[2] = 8'hD2;
        d_vals[3] = 8'hD3; d_vals[4] = 8'hD4; d_vals[5] = 8'hD5;

        @(negedge clk_i);
        tick();
        checkOutput("reset_outputs", 32'(allOut()), 32'h0);
        reset_i = 1'b0;
        #1;
        checkOutput("idle_link_v", 32'(link_v_o), 32'h0);

        // Basic send, partial ack, nack resend of the unacked tail.
        pushEntry(8'hA1); pushEntry(8'hB2); pushEntry(8'hC3);
        #1;
        checkOutput("first_link_v", 32'(link_v_o), 32'h1);
        checkOutput("first_data", 32'(link_data_o), 32'hA1);
        tick(); tick(); tick();
        checkOutput("abc_yumis", 32'(yumi_cnt), 32'd3);
        checkOutput("abc_order", {8'h0, sent_q[0], sent_q[1], sent_q[2]}, 32'h00A1B2C3);
        checkOutput("abc_no_deq", 32'(deq_cnt), 32'd0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("ack2_deq_c1", 32'(fifo_deq_v_o), 32'h1);
        tick();
        checkOutput("ack2_deq_c2", 32'(fifo_deq_v_o), 32'h1);
        tick();
        checkOutput("ack2_deq_c3", 32'(fifo_deq_v_o), 32'h0);
        checkOutput("ack2_deq_total", 32'(deq_cnt), 32'd2);
        applyStimulus(1'b0, 3'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("nack_drain_rb", 32'(fifo_rollback_v_o), 32'h0);
        tick();
        checkOutput("nack_rb_pulse", 32'(fifo_rollback_v_o), 32'h1);
        checkOutput("nack_rb_no_send", 32'(link_v_o), 32'h0);
        tick();
        checkOutput("nack_rb_done", 32'(fifo_rollback_v_o), 32'h0);
        checkOutput("resend_v", 32'(link_v_o), 32'h1);
        checkOutput("resend_data", 32'(link_data_o), 32'hC3);
        tick();
        checkOutput("resend_count", 32'(yumi_cnt), 32'd4);
        checkOutput("resend_only_c", 32'(sent_q[3]), 32'hC3);
        applyStimulus(1'b1, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("t1_deq_total", 32'(deq_cnt), 32'd3);

        // Window fills at els_p, then the ack timeout forces a full rewind.
        base_y = yumi_cnt;
        base_s = sent_q.size();
        base_d = deq_cnt;
        rb_idx = 0;
        for (int i = 0; i < 6; i++) pushEntry(d_vals[i]);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 4) begin
                checkOutput("window_yumis", 32'(yumi_cnt - base_y), 32'd4);
                checkOutput("window_stall_v", 32'(link_v_o), 32'h0);
                checkOutput("window_fifo_v", 32'(fifo_v_i), 32'h1);
            end
            if (i == 10) checkOutput("timeout_no_extra", 32'(yumi_cnt - base_y), 32'd4);
            if (fifo_rollback_v_o && rb_idx == 0) rb_idx = i;
        end
        checkOutput("timeout_rb_cycle", 32'(rb_idx), 32'd10);
        checkOutput("timeout_resends", 32'(yumi_cnt - base_y), 32'd8);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("timeout_first_%0d", k), 32'(sent_q[base_s + k]), 32'(d_vals[k]));
            checkOutput($sformatf("timeout_again_%0d", k), 32'(sent_q[base_s + 4 + k]), 32'(d_vals[k]));
        end
        applyStimulus(1'b1, 3'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick(); tick();
        applyStimulus(1'b1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick(); tick(); tick(); tick();
        checkOutput("t2_deq_total", 32'(deq_cnt - base_d), 32'd6);
        checkOutput("t2_tail", {16'h0, sent_q[sent_q.size() - 2], sent_q[sent_q.size() - 1]}, 32'h0000D4D5);
        checkOutput("t2_idle", 32'(link_v_o), 32'h0);

        // Same-cycle full ack and nack: drain all retires, then an empty rewind.
        base_d = deq_cnt;
        pushEntry(8'hE0); pushEntry(8'hE1); pushEntry(8'hE2);
        tick(); tick(); tick();
        base_y = yumi_cnt;
        checkOutput("t3_sent", {8'h0, sent_q[sent_q.size() - 3], sent_q[sent_q.size() - 2], sent_q[sent_q.size() - 1]}, 32'h00E0E1E2);
        applyStimulus(1'b1, 3'd3, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            applyStimulus(1'b0, 3'd0, 1'b0);
            deq_seq[i] = fifo_deq_v_o;
            rb_seq[i]  = fifo_rollback_v_o;
        end
        checkOutput("t3_deq_seq", {28'h0, deq_seq[1], deq_seq[2], deq_seq[3], deq_seq[4]}, 32'hE);
        checkOutput("t3_rb_seq", {29'h0, rb_seq[4], rb_seq[5], rb_seq[6]}, 32'h2);
        checkOutput("t3_deq_total", 32'(deq_cnt - base_d), 32'd3);
        checkOutput("t3_no_resend", 32'(yumi_cnt - base_y), 32'd0);

        // Reset in the middle of a drain, then normal sending with backpressure.
        pushEntry(8'hF0); pushEntry(8'hF1);
        tick(); tick();
        applyStimulus(1'b1, 3'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t4_drain_deq", 32'(fifo_deq_v_o), 32'h1);
        reset_i = 1'b1;
        #1;
        checkOutput("t4_reset_now", 32'(allOut()), 32'h0);
        tick();
        checkOutput("t4_reset_held", 32'(allOut()), 32'h0);
        reset_i = 1'b0;
        pushEntry(8'h6A);
        link_ready_and_i = 1'b0;
        #1;
        checkOutput("t4_post_v", 32'(link_v_o), 32'h1);
        checkOutput("t4_post_data", 32'(link_data_o), 32'h6A);
        checkOutput("t4_no_yumi_unready", 32'(fifo_yumi_o), 32'h0);
        checkOutput("t4_post_quiet", 32'({fifo_deq_v_o, fifo_rollback_v_o}), 32'h0);
        base_y = yumi_cnt;
        tick();
        checkOutput("t4_held_count", 32'(yumi_cnt - base_y), 32'd0);
        link_ready_and_i = 1'b1;
        tick();
        checkOutput("t4_sent_count", 32'(yumi_cnt - base_y), 32'd1);
        checkOutput("t4_sent_data", 32'(sent_q[sent_q.size() - 1]), 32'h6A);
        applyStimulus(1'b1, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t4_final_deq", 32'(fifo_deq_v_o), 32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
